// File: rtl/destuff_pkg.sv
// Shared constants and helpers for the CAN / CAN FD bit-destuffing unit.
//   RUN_LEN_DEF   : default equal-bit run length before a dynamic stuff bit
//   FIXED_LEN_DEF : default data bits between fixed stuff bits (FD CRC field)
//   CNT_W_DEF     : default width of the run / fixed counters
//   RECESSIVE     : idle bus level
//   gray3()       : 3-bit binary to Gray conversion
package destuff_pkg;

  localparam int unsigned RUN_LEN_DEF   = 5;
  localparam int unsigned FIXED_LEN_DEF = 4;
  localparam int unsigned CNT_W_DEF     = 3;
  localparam int unsigned GRAY_W        = 3;

  localparam logic RECESSIVE = 1'b1;

  // Reflected binary code: each step flips exactly one bit.
  function automatic logic [GRAY_W-1:0] gray3(input logic [GRAY_W-1:0] bin);
    return bin ^ {1'b0, bin[GRAY_W-1:1]};
  endfunction

endpackage

// File: rtl/destuff_gray_cnt.sv
// Gray-coded modulo-8 counter of removed dynamic stuff bits.
// Ports:
//   clock  in   system clock
//   reset  in   synchronous active-low reset
//   i_inc  in   one-cycle increment request
//   o_gray out  registered Gray code of the count
//   o_par  out  registered even parity (XOR) of o_gray
module destuff_gray_cnt
  import destuff_pkg::*;
(
  input  logic              clock,
  input  logic              reset,
  input  logic              i_inc,
  output logic [GRAY_W-1:0] o_gray,
  output logic              o_par
);

  logic [GRAY_W-1:0] r_bin;
  logic [GRAY_W-1:0] r_gray;
  logic              r_par;
  logic [GRAY_W-1:0] w_bin_nxt;
  logic [GRAY_W-1:0] w_gray_nxt;

  // Gray code and parity are registered alongside the binary count.
  always_comb begin
    w_bin_nxt  = r_bin + GRAY_W'(1);
    w_gray_nxt = gray3(w_bin_nxt);
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      r_bin  <= '0;
      r_gray <= '0;
      r_par  <= 1'b0;
    end else if (i_inc) begin
      r_bin  <= w_bin_nxt;
      r_gray <= w_gray_nxt;
      r_par  <= ^w_gray_nxt;
    end
  end

  assign o_gray = r_gray;
  assign o_par  = r_par;

endmodule

// File: rtl/destuffing_fd.sv
// CAN / CAN FD bit destuffing between bit timing and MACFSM.
// Removes dynamic stuff bits after RUN_LEN equal bits, removes fixed stuff
// bits every FIXED_LEN data bits in FD CRC mode, and flags stuff errors.
// Optional feature macro: DESTUFF_STUFF_COUNT_EN (Gray-coded stuff counter).
// Ports:
//   clock     in   system clock
//   reset     in   synchronous active-low reset
//   bitin     in   sampled bit
//   activ     in   sample enable; rising edge processes one bit
//   direct    in   bypass stuff handling
//   fixed     in   fixed-stuff mode (FD CRC field)
//   bitout    out  forwarded bit
//   valid     out  one-cycle strobe: bitout is a data bit
//   stuff     out  last processed bit was a removed stuff bit
//   stfer     out  sticky stuff error
//   stuff_cnt out  Gray-coded dynamic stuff count (000 without feature)
//   stuff_par out  parity of stuff_cnt (0 without feature)
module destuffing_fd
  import destuff_pkg::*;
#(
  parameter int unsigned RUN_LEN   = RUN_LEN_DEF,
  parameter int unsigned FIXED_LEN = FIXED_LEN_DEF,
  parameter int unsigned CNT_W     = CNT_W_DEF
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              bitin,
  input  logic              activ,
  input  logic              direct,
  input  logic              fixed,
  output logic              bitout,
  output logic              valid,
  output logic              stuff,
  output logic              stfer,
  output logic [GRAY_W-1:0] stuff_cnt,
  output logic              stuff_par
);

  logic [CNT_W-1:0] r_count;
  logic [CNT_W-1:0] r_fcnt;
  logic             r_buff;
  logic             r_edged;
  logic             r_bitout;
  logic             r_valid;
  logic             r_stuff;
  logic             r_stfer;

  logic [CNT_W-1:0] w_count;
  logic [CNT_W-1:0] w_fcnt;
  logic             w_buff;
  logic             w_bitout;
  logic             w_valid;
  logic             w_stuff;
  logic             w_stfer;
  logic             w_event;
  logic             w_run_full;

  // One bit is processed on the first clock of each activ high period.
  assign w_event    = activ & ~r_edged;
  assign w_run_full = (r_count == CNT_W'(RUN_LEN));

  // Next-state: the inactive mode's counter is held at zero every clock.
  always_comb begin
    w_count  = fixed ? '0 : r_count;
    w_fcnt   = fixed ? r_fcnt : '0;
    w_buff   = r_buff;
    w_bitout = r_bitout;
    w_valid  = 1'b0;
    w_stuff  = r_stuff;
    w_stfer  = r_stfer;

    if (w_event) begin
      w_bitout = bitin;
      if (direct) begin
        w_valid = 1'b1;
        w_stuff = 1'b0;
      end else if (fixed) begin
        if (r_fcnt == '0) begin
          // Fixed stuff bit must be the complement of the last data bit.
          w_valid = 1'b0;
          w_fcnt  = CNT_W'(FIXED_LEN);
          if (bitin != r_buff) begin
            w_stuff = 1'b1;
            w_buff  = bitin;
          end else begin
            w_stfer = 1'b1;
            w_stuff = 1'b0;
          end
        end else begin
          w_valid = 1'b1;
          w_stuff = 1'b0;
          w_buff  = bitin;
          w_fcnt  = r_fcnt - CNT_W'(1);
        end
      end else begin
        if (r_count == '0) begin
          w_buff  = bitin;
          w_count = CNT_W'(1);
          w_valid = 1'b1;
          w_stuff = 1'b0;
        end else if (w_run_full) begin
          w_valid = 1'b0;
          if (bitin != r_buff) begin
            // Stuff bit starts the next run as its first bit.
            w_stuff = 1'b1;
            w_buff  = bitin;
            w_count = CNT_W'(1);
          end else begin
            w_stfer = 1'b1;
            w_stuff = 1'b0;
            w_count = '0;
          end
        end else if (bitin != r_buff) begin
          w_buff  = bitin;
          w_count = CNT_W'(1);
          w_valid = 1'b1;
          w_stuff = 1'b0;
        end else begin
          w_count = r_count + CNT_W'(1);
          w_valid = 1'b1;
          w_stuff = 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      r_count  <= '0;
      r_fcnt   <= '0;
      r_buff   <= RECESSIVE;
      r_edged  <= 1'b0;
      r_bitout <= RECESSIVE;
      r_valid  <= 1'b0;
      r_stuff  <= 1'b0;
      r_stfer  <= 1'b0;
    end else begin
      r_count  <= w_count;
      r_fcnt   <= w_fcnt;
      r_buff   <= w_buff;
      r_edged  <= activ;
      r_bitout <= w_bitout;
      r_valid  <= w_valid;
      r_stuff  <= w_stuff;
      r_stfer  <= w_stfer;
    end
  end

  assign bitout = r_bitout;
  assign valid  = r_valid;
  assign stuff  = r_stuff;
  assign stfer  = r_stfer;

`ifdef DESTUFF_STUFF_COUNT_EN
  logic w_dyn_stuff;

  // Only dynamic stuff bits are counted; fixed and direct bits are not.
  assign w_dyn_stuff = w_event & ~direct & ~fixed & w_run_full & (bitin != r_buff);

  destuff_gray_cnt u_gray_cnt (
    .clock  (clock),
    .reset  (reset),
    .i_inc  (w_dyn_stuff),
    .o_gray (stuff_cnt),
    .o_par  (stuff_par)
  );
`else
  assign stuff_cnt = '0;
  assign stuff_par = 1'b0;
`endif

endmodule

// File: tb/tb_destuffing_fd.sv
// Self-checking bench for destuffing_fd against a behavioural bit-stream model.
module tb_destuffing_fd;

  localparam int RUN_LEN   = 5;
  localparam int FIXED_LEN = 4;

  logic       clock  = 1'b0;
  logic       reset  = 1'b0;
  logic       bitin  = 1'b1;
  logic       activ  = 1'b0;
  logic       direct = 1'b0;
  logic       fixed  = 1'b0;
  logic       bitout;
  logic       valid;
  logic       stuff;
  logic       stfer;
  logic [2:0] stuff_cnt;
  logic       stuff_par;
  logic [7:0] obs;

  int n_vec = 0;
  int n_err = 0;

  // Model state: length of current equal-bit run, last data level,
  // data bits left before the next fixed stuff bit, stuff-bit tally.
  int   m_run, m_fleft, m_scnt;
  logic m_last, m_stfer, m_stuff, m_bitout, m_valid;

  destuffing_fd dut (
    .clock     (clock),
    .reset     (reset),
    .bitin     (bitin),
    .activ     (activ),
    .direct    (direct),
    .fixed     (fixed),
    .bitout    (bitout),
    .valid     (valid),
    .stuff     (stuff),
    .stfer     (stfer),
    .stuff_cnt (stuff_cnt),
    .stuff_par (stuff_par)
  );

  always #5 clock = ~clock;

  assign obs = {bitout, valid, stuff, stfer, stuff_cnt, stuff_par};

  function automatic logic [2:0] exp_gray();
    int n;
    n = m_scnt % 8;
`ifdef DESTUFF_STUFF_COUNT_EN
    return 3'(n ^ (n >> 1));
`else
    return 3'(n & 0);
`endif
  endfunction

  function automatic logic [7:0] exp_vec();
    logic [2:0] g;
    g = exp_gray();
    return {m_bitout, m_valid, m_stuff, m_stfer, g, ^g};
  endfunction

  function automatic void model_reset();
    m_run = 0; m_fleft = 0; m_scnt = 0;
    m_last = 1'b1; m_stfer = 1'b0; m_stuff = 1'b0;
    m_bitout = 1'b1; m_valid = 1'b0;
  endfunction

  function automatic void model_step(input logic b, input logic d, input logic f);
    m_bitout = b;
    if (f) m_run = 0; else m_fleft = 0;
    if (d) begin
      m_valid = 1'b1; m_stuff = 1'b0;
    end else if (f) begin
      if (m_fleft == 0) begin
        m_valid = 1'b0;
        m_fleft = FIXED_LEN;
        if (b != m_last) begin m_stuff = 1'b1; m_last = b; end
        else begin m_stuff = 1'b0; m_stfer = 1'b1; end
      end else begin
        m_valid = 1'b1; m_stuff = 1'b0; m_last = b; m_fleft--;
      end
    end else if (m_run == RUN_LEN) begin
      m_valid = 1'b0;
      if (b != m_last) begin
        m_stuff = 1'b1; m_last = b; m_run = 1; m_scnt++;
      end else begin
        m_stuff = 1'b0; m_stfer = 1'b1; m_run = 0;
      end
    end else begin
      m_valid = 1'b1; m_stuff = 1'b0;
      if (m_run == 0 || b != m_last) begin m_last = b; m_run = 1; end
      else m_run++;
    end
  endfunction

  // Present one bit with a fresh activ rising edge; returns just after the edge.
  task automatic drive_event(input logic b, input logic d, input logic f);
    @(negedge clock);
    reset = 1'b1; bitin = b; direct = d; fixed = f; activ = 1'b1;
    model_step(b, d, f);
    @(posedge clock); #1;
  endtask

  task automatic idle_clock();
    @(negedge clock);
    reset = 1'b1; activ = 1'b0;
    m_valid = 1'b0;
    @(posedge clock); #1;
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset = 1'b0; activ = 1'b0; direct = 1'b0; fixed = 1'b0; bitin = 1'b1;
    model_reset();
    @(posedge clock); #1;
  endtask

  task automatic test_reset();
    do_reset();
    n_vec++;
    if (obs !== 8'b1000_0000) begin
      n_err++; $display("FAIL reset_state: got %b expected %b", obs, 8'b1000_0000);
    end
  endtask

  task automatic test_dyn_stuff();
    logic seq [7] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
    do_reset();
    for (int i = 0; i < 7; i++) begin
      drive_event(seq[i], 1'b0, 1'b0);
      n_vec++;
      if (obs !== exp_vec()) begin
        n_err++; $display("FAIL dyn_stuff ev%0d: got %b expected %b", i + 1, obs, exp_vec());
      end
      if (i == 5) begin
        n_vec++;
        if ({valid, stuff} !== 2'b01) begin
          n_err++; $display("FAIL dyn_stuff_bit6: got %b expected 01", {valid, stuff});
        end
      end
      idle_clock();
      n_vec++;
      if (obs !== exp_vec()) begin
        n_err++; $display("FAIL dyn_stuff_idle ev%0d: got %b expected %b", i + 1, obs, exp_vec());
      end
    end
  endtask

  task automatic test_stuff_error();
    do_reset();
    for (int i = 0; i < 16; i++) begin
      drive_event((i < 6) ? 1'b0 : 1'(i % 2), 1'b0, 1'b0);
      n_vec++;
      if (obs !== exp_vec()) begin
        n_err++; $display("FAIL stuff_error ev%0d: got %b expected %b", i + 1, obs, exp_vec());
      end
      if (i >= 5) begin
        n_vec++;
        if (stfer !== 1'b1) begin
          n_err++; $display("FAIL stfer_sticky ev%0d: got %b expected 1", i + 1, stfer);
        end
      end
      idle_clock();
    end
    do_reset();
    n_vec++;
    if (stfer !== 1'b0) begin
      n_err++; $display("FAIL stfer_reset: got %b expected 0", stfer);
    end
  endtask

  task automatic test_fixed(input logic last_bit);
    logic seq [6];
    seq = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, last_bit};
    do_reset();
    drive_event(1'b0, 1'b0, 1'b0);
    idle_clock();
    for (int i = 0; i < 6; i++) begin
      drive_event(seq[i], 1'b0, 1'b1);
      n_vec++;
      if (obs !== exp_vec()) begin
        n_err++; $display("FAIL fixed_%0b ev%0d: got %b expected %b", last_bit, i + 1, obs, exp_vec());
      end
      idle_clock();
    end
    n_vec++;
    if (stfer !== ~last_bit) begin
      n_err++; $display("FAIL fixed_stfer_%0b: got %b expected %b", last_bit, stfer, ~last_bit);
    end
  endtask

  task automatic test_handshake();
    do_reset();
    drive_event(1'b0, 1'b0, 1'b0);
    n_vec++;
    if (valid !== 1'b1) begin
      n_err++; $display("FAIL handshake_first: got %b expected 1", valid);
    end
    for (int i = 0; i < 6; i++) begin
      @(posedge clock); #1;
      n_vec++;
      if (valid !== 1'b0) begin
        n_err++; $display("FAIL handshake_hold cyc%0d: got %b expected 0", i + 2, valid);
      end
    end
    idle_clock();
  endtask

  task automatic test_direct();
    do_reset();
    for (int i = 0; i < 3; i++) begin drive_event(1'b1, 1'b0, 1'b0); idle_clock(); end
    for (int i = 0; i < 8; i++) begin
      drive_event(1'b0, 1'b1, 1'b0);
      n_vec++;
      if (obs !== exp_vec()) begin
        n_err++; $display("FAIL direct ev%0d: got %b expected %b", i + 1, obs, exp_vec());
      end
      idle_clock();
    end
    // Run of three 1s survives the bypass: two more fill it, a sixth errors.
    for (int i = 0; i < 3; i++) begin drive_event(1'b1, 1'b0, 1'b0); idle_clock(); end
    n_vec++;
    if (stfer !== 1'b1) begin
      n_err++; $display("FAIL direct_count_held: got %b expected 1", stfer);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    for (int i = 0; i < 4; i++) begin drive_event(1'b0, 1'b0, 1'b0); idle_clock(); end
    @(negedge clock);
    reset = 1'b0; activ = 1'b1; bitin = 1'b0; direct = 1'b0; fixed = 1'b0;
    model_reset();
    @(posedge clock); #1;
    n_vec++;
    if (obs !== 8'b1000_0000) begin
      n_err++; $display("FAIL reset_mid_state: got %b expected %b", obs, 8'b1000_0000);
    end
    @(negedge clock);
    reset = 1'b1;
    model_step(1'b0, 1'b0, 1'b0);
    @(posedge clock); #1;
    n_vec++;
    if (obs !== exp_vec()) begin
      n_err++; $display("FAIL reset_mid_first_event: got %b expected %b", obs, exp_vec());
    end
    idle_clock();
    for (int i = 1; i < 6; i++) begin
      drive_event((i < 5) ? 1'b0 : 1'b1, 1'b0, 1'b0);
      n_vec++;
      if (obs !== exp_vec()) begin
        n_err++; $display("FAIL reset_mid ev%0d: got %b expected %b", i + 1, obs, exp_vec());
      end
      idle_clock();
    end
  endtask

  task automatic test_gray_wrap();
    logic       cur;
    logic [2:0] tbl [8] = '{3'b001, 3'b011, 3'b010, 3'b110, 3'b111, 3'b101, 3'b100, 3'b000};
    do_reset();
    cur = 1'b1;
    for (int i = 0; i < 5; i++) begin drive_event(cur, 1'b0, 1'b0); idle_clock(); end
    for (int k = 0; k < 8; k++) begin
      cur = ~cur;
      drive_event(cur, 1'b0, 1'b0);
      n_vec++;
      if (obs !== exp_vec()) begin
        n_err++; $display("FAIL gray_wrap stuff%0d: got %b expected %b", k + 1, obs, exp_vec());
      end
`ifdef DESTUFF_STUFF_COUNT_EN
      n_vec++;
      if ({stuff_cnt, stuff_par} !== {tbl[k], ^tbl[k]}) begin
        n_err++; $display("FAIL gray_table stuff%0d: got %b expected %b", k + 1, {stuff_cnt, stuff_par}, {tbl[k], ^tbl[k]});
      end
`else
      n_vec++;
      if ({stuff_cnt, stuff_par} !== 4'b0000) begin
        n_err++; $display("FAIL gray_off stuff%0d: got %b expected 0000 (table %b)", k + 1, {stuff_cnt, stuff_par}, tbl[k]);
      end
`endif
      idle_clock();
      for (int j = 0; j < 4; j++) begin drive_event(cur, 1'b0, 1'b0); idle_clock(); end
    end
  endtask

  task automatic test_random();
    logic f;
    f = 1'b0;
    do_reset();
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(39) == 0) do_reset();
      if ($urandom_range(9) == 0) f = ~f;
      drive_event(1'($urandom_range(1)), ($urandom_range(7) == 0), f);
      n_vec++;
      if (obs !== exp_vec()) begin
        n_err++; $display("FAIL random ev%0d: got %b expected %b", i, obs, exp_vec());
      end
      for (int h = $urandom_range(2); h > 0; h--) begin
        @(posedge clock); #1;
      end
      idle_clock();
      n_vec++;
      if (obs !== exp_vec()) begin
        n_err++; $display("FAIL random_idle ev%0d: got %b expected %b", i, obs, exp_vec());
      end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_dyn_stuff();
    test_stuff_error();
    test_fixed(1'b1);
    test_fixed(1'b0);
    test_handshake();
    test_direct();
    test_reset_mid();
    test_gray_wrap();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
